// File: rtl/seq_factorial_pkg.sv
// Shared types and constants for the sequential factorial engine.
// Holds the FSM state encoding, the mode codes and the default accumulator width.
package seq_factorial_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StCalc
   } state_e;

   localparam logic MODE_FACT  = 1'b0;
   localparam logic MODE_DFACT = 1'b1;

   // Wide enough that 15! still fits; callers may narrow it.
   function automatic int unsigned default_w(input int unsigned n);
      return 20 * n;
   endfunction

endpackage

// File: rtl/factorial_mul_step.sv
// One W x N multiply step of the factorial engine: truncated product plus step overflow.
// Kept as its own block so the multiplier can be pipelined later without touching the FSM.
module factorial_mul_step #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 80
) (
   input  logic [W-1:0] acc,
   input  logic [N-1:0] idx,
   output logic [W-1:0] prod,
   output logic         step_ovf
);

   logic [W+N-1:0] full;

   always_comb begin
      full     = (W+N)'(acc) * (W+N)'(idx);
      prod     = full[W-1:0];
      step_ovf = |full[W+N-1:W];
   end

endmodule

// File: rtl/seq_factorial_engine.sv
// Multi-cycle n! / n!! engine: one multiply per clock behind a start/ready handshake.
// Result and overflow are held between completions; done pulses for one cycle.
module seq_factorial_engine
   import seq_factorial_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = default_w(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         mode,
   input  logic [N-1:0] number,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         overflow
);

   state_e         state_q, state_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [N-1:0]   idx_q, idx_d;
   logic           mode_q, mode_d;
   logic           ovf_acc_q, ovf_acc_d;
   logic [W-1:0]   result_q, result_d;
   logic           overflow_q, overflow_d;
   logic           done_q, done_d;

   logic [W-1:0]   prod;
   logic           step_ovf;
   logic [N-1:0]   step;

   factorial_mul_step #(
      .N (N),
      .W (W)
   ) u_mul_step (
      .acc      (acc_q),
      .idx      (idx_q),
      .prod     (prod),
      .step_ovf (step_ovf)
   );

   always_comb begin
      step = (mode_q == MODE_DFACT) ? N'(2) : N'(1);
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      mode_d     = mode_q;
      ovf_acc_d  = ovf_acc_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               acc_d     = W'(1);
               idx_d     = number;
               mode_d    = mode;
               ovf_acc_d = 1'b0;
               state_d   = StCalc;
            end
         end
         StCalc: begin
            if (idx_q >= N'(2)) begin
               acc_d     = prod;
               ovf_acc_d = ovf_acc_q | step_ovf;
               // Saturate so an odd/even mismatch can never wrap the index.
               idx_d     = (idx_q >= step) ? (idx_q - step) : '0;
            end else begin
               result_d   = acc_q;
               overflow_d = ovf_acc_q;
               done_d     = 1'b1;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         acc_q      <= '0;
         idx_q      <= '0;
         mode_q     <= MODE_FACT;
         ovf_acc_q  <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         mode_q     <= mode_d;
         ovf_acc_q  <= ovf_acc_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      ready    = (state_q == StIdle);
      busy     = ~ready;
      done     = done_q;
      result   = result_q;
      overflow = overflow_q;
   end

endmodule

// File: tb/tb_seq_factorial_engine.sv
// Self-checking bench: a wide (W=80) and a narrow (W=16) engine share one request stream
// and are compared against a plain-arithmetic model of n! / n!!.
module tb_seq_factorial_engine;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        mode;
   logic [3:0]  number;

   logic        ready80, busy80, done80, ovf80;
   logic [79:0] result80;
   logic        ready16, busy16, done16, ovf16;
   logic [15:0] result16;

   int checks = 0;
   int errors = 0;

   seq_factorial_engine #(.N(4), .W(80)) dut80 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mode     (mode),
      .number   (number),
      .ready    (ready80),
      .busy     (busy80),
      .done     (done80),
      .result   (result80),
      .overflow (ovf80)
   );

   seq_factorial_engine #(.N(4), .W(16)) dut16 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mode     (mode),
      .number   (number),
      .ready    (ready16),
      .busy     (busy16),
      .done     (done16),
      .result   (result16),
      .overflow (ovf16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Product of n, n-s, n-2s, ... down to 2, each step truncated to w bits.
   function automatic void ref_model(input logic md, input int n, input int w,
                                     output logic [95:0] res, output bit ovf, output int m);
      logic [95:0] p;
      logic [95:0] mask;
      mask = (96'd1 << w) - 96'd1;
      res  = 96'd1;
      ovf  = 1'b0;
      m    = 0;
      for (int i = n; i >= 2; i -= (md ? 2 : 1)) begin
         p = res * 96'(i);
         if ((p >> w) != 96'd0) ovf = 1'b1;
         res = p & mask;
         m++;
      end
   endfunction

   task automatic accept(input logic md, input logic [3:0] num);
      @(negedge clk);
      start  = 1'b1;
      mode   = md;
      number = num;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_accept", 96'(busy80), 96'd1);
   endtask

   task automatic finish_req(input logic md, input logic [3:0] num, input int elapsed);
      logic [95:0] r80, r16;
      bit          o80, o16;
      int          m, cyc;
      ref_model(md, int'(num), 80, r80, o80, m);
      ref_model(md, int'(num), 16, r16, o16, m);
      cyc = elapsed;
      while (done80 !== 1'b1 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("latency", 96'(cyc), 96'(m + 1));
      check("done16", 96'(done16), 96'd1);
      check("ready_at_done", 96'(ready80), 96'd1);
      check("busy_at_done", 96'(busy16), 96'd0);
      check("result80", 96'(result80), r80);
      check("ovf80", 96'(ovf80), 96'(o80));
      check("result16", 96'(result16), r16);
      check("ovf16", 96'(ovf16), 96'(o16));
   endtask

   task automatic do_req(input logic md, input logic [3:0] num);
      accept(md, num);
      finish_req(md, num, 0);
      @(posedge clk);
      #1;
      check("done_single_pulse", 96'(done80), 96'd0);
   endtask

   initial begin
      int dones;
      rst_n  = 1'b0;
      start  = 1'b0;
      mode   = 1'b0;
      number = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", 96'(ready80), 96'd1);
      check("rst_busy", 96'(busy80), 96'd0);
      check("rst_done", 96'(done80), 96'd0);
      check("rst_result", 96'(result80), 96'd0);
      check("rst_ovf", 96'(ovf16), 96'd0);
      rst_n = 1'b1;

      do_req(1'b0, 4'd5);
      check("fact5", 96'(result80), 96'd120);
      do_req(1'b0, 4'd0);
      check("fact0", 96'(result80), 96'd1);
      do_req(1'b0, 4'd1);
      check("fact1", 96'(result80), 96'd1);
      do_req(1'b0, 4'd15);
      check("fact15", 96'(result80), 96'd1307674368000);
      check("fact15_ovf", 96'(ovf80), 96'd0);
      do_req(1'b1, 4'd7);
      check("dfact7", 96'(result80), 96'd105);
      do_req(1'b1, 4'd6);
      check("dfact6", 96'(result80), 96'd48);
      do_req(1'b0, 4'd8);
      check("w16_fact8", 96'(result16), 96'd40320);
      check("w16_fact8_ovf", 96'(ovf16), 96'd0);
      do_req(1'b0, 4'd9);
      check("w16_fact9", 96'(result16), 96'd35200);
      check("w16_fact9_ovf", 96'(ovf16), 96'd1);
      do_req(1'b0, 4'd3);
      check("w16_fact3", 96'(result16), 96'd6);
      check("w16_fact3_ovf", 96'(ovf16), 96'd0);

      // Start pulses while busy must be ignored.
      accept(1'b0, 4'd10);
      repeat (2) begin
         @(negedge clk);
         start  = 1'b1;
         mode   = 1'b1;
         number = 4'd2;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      finish_req(1'b0, 4'd10, 2);
      check("ignore_result", 96'(result80), 96'd3628800);
      dones = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (done80) dones++;
      end
      check("ignore_no_extra_done", 96'(dones), 96'd0);

      // Back-to-back: new request raised in the done cycle.
      accept(1'b0, 4'd3);
      finish_req(1'b0, 4'd3, 0);
      start  = 1'b1;
      mode   = 1'b0;
      number = 4'd4;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b_accepted", 96'(busy80), 96'd1);
      finish_req(1'b0, 4'd4, 0);
      check("b2b_result", 96'(result80), 96'd24);

      // Asynchronous reset mid-calculation.
      accept(1'b0, 4'd12);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("abort_ready", 96'(ready80), 96'd1);
      check("abort_busy", 96'(busy16), 96'd0);
      check("abort_result80", 96'(result80), 96'd0);
      check("abort_result16", 96'(result16), 96'd0);
      check("abort_ovf", 96'(ovf16), 96'd0);
      dones = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done80 || done16) dones++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done80 || done16) dones++;
      end
      check("abort_no_done", 96'(dones), 96'd0);
      do_req(1'b0, 4'd6);

      for (int k = 0; k < 40; k++) begin
         do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_factorial_engine.md
Name: seq_factorial_engine

Overview:
- Multi-cycle, parametrised factorial unit that replaces the combinational N-bit factorial block wherever a long combinational multiply chain fails timing.
- Computes n! or the double factorial n!! using one W x N multiply per clock.
- Accepts a request through a start/ready handshake and returns the result with a one-cycle done pulse and a sticky overflow flag.
- Sits in the arithmetic datapath as a request/response slave to a controller FSM.

Parameters:
- N, 4, width of the operand input (number); n ranges 0..2^N-1.
- W, 20*N, width of the accumulator and result; products are truncated modulo 2^W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; accepted only when ready=1.
- mode  input  1  0 = n!, 1 = n!! (double factorial); sampled at accept.
- number  input  N  operand n; sampled at accept.
- ready  output  1  high in IDLE, i.e. a new request can be accepted.
- busy  output  1  high in CALC; equal to ~ready.
- done  output  1  single-cycle pulse when result/overflow update.
- result  output  W  final product mod 2^W; held until the next completion.
- overflow  output  1  1 if any intermediate product exceeded W bits; held with result.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, ready=1, busy=0, done=0, result=0, overflow=0, internal acc=0, idx=0, ovf_acc=0.
- Reset asserted mid-calculation aborts the operation with no done pulse. Outputs return to the reset values immediately.
- FSM has two states: IDLE and CALC.
- **IDLE:**
  - On an edge with start=1, the request is accepted (edge T0).
  - On acceptance: acc<=1, idx<=number, step<=mode?2:1, ovf_acc<=0, state<=CALC.
  - done deasserts on any edge where it is not being set.
- **CALC**, per edge:
  - If idx>=2:
    - acc<=(acc*idx)[W-1:0].
    - ovf_acc<=ovf_acc | (|(acc*idx)[W+N-1:W]).
    - idx<=idx-step, saturating at 0.
  - Else: result<=acc, overflow<=ovf_acc, done<=1, state<=IDLE.
- Multiply count m:
  - Factorial: max(0, n-1).
  - Double factorial: floor(n/2).
- Latency: done is high in the cycle following edge T(m+1). ready returns high in that same cycle. Back-to-back: start may be asserted during the done cycle and is accepted on that edge.
- start while busy is ignored. It is neither queued nor does it alter the computation. number and mode changes during CALC have no effect.
- 0! = 1! = 0!! = 1!! = 1 with m=0, so done arrives on T1.
- Full product width is W+N. Overflow detection uses the upper N bits of each step's product. Truncation per step gives the exact result mod 2^W.
- result and overflow change only on the completion edge or on reset.

Decomposition:
- Shared package seq_factorial_pkg contains:
  - The state enum (IDLE, CALC).
  - Constants MODE_FACT=0 and MODE_DFACT=1.
  - The default W derivation (20*N).
- One combinational sub-module, factorial_mul_step (params N, W):
  - Inputs: acc and idx.
  - Outputs: the truncated product and a step-overflow bit.
  - Keeps the multiplier isolated so it can be pipelined later.

Test Plan:
- N=4, W=80, mode=0, number=5, start pulse -> done 5 cycles after the accept edge, result=120, overflow=0, busy high for exactly 5 cycles.
- mode=0, number=0, then number=1 -> each done 1 cycle after accept, result=1. mode=0, number=15 -> result=1307674368000, overflow=0.
- mode=1, number=7 -> result=105, done after 4 cycles. mode=1, number=6 -> result=48, done after 4 cycles.
- N=4, W=16, mode=0: number=8 -> result=40320, overflow=0. number=9 -> result=35200 (362880 mod 65536), overflow=1. A following number=3 request -> result=6, overflow=0 (flag cleared per request).
- Start number=10, then re-pulse start with number=2 during CALC -> ignored; result=3628800, then a single done.
- Back-to-back: assert start with number=4 in the done cycle -> accepted, result=24.
- Assert rst_n=0 mid-CALC, then release -> all outputs 0 (ready=1), no done pulse. The next request completes normally.
